// File: rtl/fir_multichannel.sv
// Time-shared multichannel FIR filter: one multiply-accumulate engine walks every channel
// of a sample set in turn, with coefficients read from an external one-cycle-latency RAM.
module fir_multichannel #(
    parameter int NCH        = 2,
    parameter int NTAPS      = 64,
    parameter int DW         = 18,
    parameter int CW         = 16,
    parameter int COEF_BANKS = 1,
    parameter int CAW        = $clog2(COEF_BANKS * NTAPS)
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                endata,
    input  logic [NCH*DW-1:0]   datain,
    input  logic [NCH-1:0]      bypass,
    input  logic                clear_ovr,
    output logic [CAW-1:0]      coefaddress,
    input  logic [CW-1:0]       coefdata,
    output logic [NCH*DW-1:0]   dataout,
    output logic                dout_valid,
    output logic                busy,
    output logic                overrun
);
    localparam int TW   = $clog2(NTAPS);
    localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int DLW  = CHW + TW;
    localparam int ACCW = DW + CW + TW;

    localparam logic signed [ACCW:0] RND    = (ACCW+1)'(2 ** (CW - 2));
    localparam logic signed [ACCW:0] SAT_HI = (ACCW+1)'((2 ** (DW - 1)) - 1);
    localparam logic signed [ACCW:0] SAT_LO = (ACCW+1)'(-(2 ** (DW - 1)));

    typedef enum logic [2:0] {INIT, IDLE, LOAD, MAC, STORE, UPDATE} state_t;

    state_t state, state_next;

    logic [DLW-1:0]           init_cnt;
    logic [TW-1:0]            wp;
    logic [CHW-1:0]           ch;
    logic [TW:0]              k;
    logic [NCH*DW-1:0]        sample_q;
    logic [NCH-1:0]           bypass_q;
    logic [NCH*DW-1:0]        result_q;
    logic                     v1, v2;
    logic signed [DW-1:0]     x_q;
    logic signed [DW+CW-1:0]  prod_q;
    logic signed [ACCW-1:0]   acc;

    logic [DW-1:0]            dline [2**DLW];

    logic                     issue;
    logic                     last_ch;
    logic [TW-1:0]            rd_tap;
    logic [CAW-1:0]           coef_idx;
    logic signed [ACCW:0]     rounded;
    logic signed [ACCW:0]     shifted;
    logic [DW-1:0]            sat_val;
    logic [DW-1:0]            store_val;
    logic [NCH*DW-1:0]        out_next;

    assign busy    = (state != IDLE);
    assign issue   = (state == MAC) && !k[TW];
    assign last_ch = (ch == CHW'(NCH - 1));
    assign rd_tap  = wp - k[TW-1:0];

    generate
        if (COEF_BANKS == 1) begin : g_shared
            assign coef_idx = CAW'(k[TW-1:0]);
        end else begin : g_banked
            assign coef_idx = CAW'({ch, k[TW-1:0]});
        end
    endgenerate

    assign coefaddress = issue ? coef_idx : '0;

    always_comb begin
        state_next = state;
        case (state)
            INIT:    if (init_cnt == DLW'(NCH * NTAPS - 1)) state_next = IDLE;
            IDLE:    if (endata) state_next = LOAD;
            LOAD:    if (last_ch) state_next = MAC;
            MAC:     if (k == (TW+1)'(NTAPS + 1)) state_next = STORE;
            STORE:   state_next = last_ch ? UPDATE : MAC;
            UPDATE:  state_next = IDLE;
            default: state_next = INIT;
        endcase
    end

    // Round half up, then clamp into the sample range; bypassed channels pass the captured input.
    always_comb begin
        rounded = {acc[ACCW-1], acc} + RND;
        shifted = rounded >>> (CW - 1);
        if (shifted > SAT_HI)
            sat_val = SAT_HI[DW-1:0];
        else if (shifted < SAT_LO)
            sat_val = SAT_LO[DW-1:0];
        else
            sat_val = shifted[DW-1:0];
        store_val = bypass_q[ch] ? sample_q[ch*DW +: DW] : sat_val;
        out_next = result_q;
        out_next[ch*DW +: DW] = store_val;
    end

    // Delay-line RAM: sample read is registered so it lines up with the coefficient RAM output.
    always_ff @(posedge clock) begin
        if (state == INIT)
            dline[init_cnt] <= '0;
        else if (state == LOAD)
            dline[{ch, wp}] <= sample_q[ch*DW +: DW];
        x_q <= dline[{ch, rd_tap}];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= INIT;
            init_cnt   <= '0;
            wp         <= '0;
            ch         <= '0;
            k          <= '0;
            sample_q   <= '0;
            bypass_q   <= '0;
            result_q   <= '0;
            v1         <= 1'b0;
            v2         <= 1'b0;
            prod_q     <= '0;
            acc        <= '0;
            dataout    <= '0;
            dout_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_next;
            dout_valid <= 1'b0;
            v1         <= issue;
            v2         <= v1;
            prod_q     <= x_q * $signed(coefdata);
            if (v2)
                acc <= acc + ACCW'(prod_q);

            if (endata && busy)
                overrun <= 1'b1;
            else if (clear_ovr)
                overrun <= 1'b0;

            case (state)
                INIT: begin
                    init_cnt <= (state_next == IDLE) ? '0 : init_cnt + 1'b1;
                end
                IDLE: begin
                    if (endata) begin
                        sample_q <= datain;
                        bypass_q <= bypass;
                        ch       <= '0;
                    end
                end
                LOAD: begin
                    ch  <= last_ch ? '0 : ch + 1'b1;
                    k   <= '0;
                    acc <= '0;
                end
                MAC: begin
                    k <= k + 1'b1;
                end
                STORE: begin
                    acc                   <= '0;
                    k                     <= '0;
                    result_q[ch*DW +: DW] <= store_val;
                    // The last channel's result goes straight to the output alongside the others.
                    if (last_ch) begin
                        dataout    <= out_next;
                        dout_valid <= 1'b1;
                    end else begin
                        ch <= ch + 1'b1;
                    end
                end
                UPDATE: begin
                    wp <= wp + 1'b1;
                    ch <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fir_multichannel.sv
// Self-checking bench for fir_multichannel: a shared-coefficient instance driven through a
// scoreboard, plus a two-bank instance for per-channel coefficient sets.
module tb_fir_multichannel;
    localparam int NCH   = 2;
    localparam int NTAPS = 64;
    localparam int DW    = 18;
    localparam int CW    = 16;
    localparam int CAW1  = 6;
    localparam int CAW2  = 7;
    localparam int LAT   = NCH * (NTAPS + 4) + 1;
    localparam int YMAX  = (2 ** (DW - 1)) - 1;
    localparam int YMIN  = -(2 ** (DW - 1));

    typedef struct {
        int         x0;
        int         x1;
        logic [1:0] byp;
        int         e0;
        int         e1;
    } vec_t;

    typedef struct {
        int e0;
        int e1;
    } exp_t;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              endata = 1'b0;
    logic              clear_ovr = 1'b0;
    logic [NCH*DW-1:0] datain = '0;
    logic [NCH-1:0]    bypass = '0;
    logic [CAW1-1:0]   coefaddress;
    logic [CW-1:0]     coefdata = '0;
    logic [NCH*DW-1:0] dataout;
    logic              dout_valid;
    logic              busy;
    logic              overrun;

    logic              endata2 = 1'b0;
    logic [NCH*DW-1:0] datain2 = '0;
    logic [NCH-1:0]    bypass2 = '0;
    logic [CAW2-1:0]   coefaddress2;
    logic [CW-1:0]     coefdata2 = '0;
    logic [NCH*DW-1:0] dataout2;
    logic              dout_valid2;
    logic              busy2;
    logic              overrun2;

    int h1 [NTAPS];
    int h2 [2*NTAPS];
    int hist [NCH][NTAPS];
    int mp = NTAPS - 1;

    exp_t sb [$];
    int total = 0;
    int bad = 0;
    int pulses = 0;
    int exp_pulses = 0;

    fir_multichannel #(.NCH(NCH), .NTAPS(NTAPS), .DW(DW), .CW(CW), .COEF_BANKS(1)) dut (
        .clock(clock), .reset_n(reset_n), .endata(endata), .datain(datain),
        .bypass(bypass), .clear_ovr(clear_ovr), .coefaddress(coefaddress),
        .coefdata(coefdata), .dataout(dataout), .dout_valid(dout_valid),
        .busy(busy), .overrun(overrun)
    );

    fir_multichannel #(.NCH(NCH), .NTAPS(NTAPS), .DW(DW), .CW(CW), .COEF_BANKS(2)) dut_banks (
        .clock(clock), .reset_n(reset_n), .endata(endata2), .datain(datain2),
        .bypass(bypass2), .clear_ovr(clear_ovr), .coefaddress(coefaddress2),
        .coefdata(coefdata2), .dataout(dataout2), .dout_valid(dout_valid2),
        .busy(busy2), .overrun(overrun2)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        coefdata  <= CW'(h1[coefaddress]);
        coefdata2 <= CW'(h2[coefaddress2]);
    end

    always @(negedge clock) begin
        if (dout_valid)
            pulses <= pulses + 1;
    end

    task automatic checkOutput(input string name, input logic signed [63:0] got,
                               input logic signed [63:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, expv);
        end
    endtask

    function automatic int getCh(input logic [NCH*DW-1:0] v, input int c);
        logic signed [DW-1:0] s;
        s = v[c*DW +: DW];
        return int'(s);
    endfunction

    function automatic void modelReset();
        for (int c = 0; c < NCH; c++)
            for (int k = 0; k < NTAPS; k++)
                hist[c][k] = 0;
        mp = NTAPS - 1;
    endfunction

    function automatic void modelPush(input int x0, input int x1);
        mp = (mp + 1) % NTAPS;
        hist[0][mp] = x0;
        hist[1][mp] = x1;
    endfunction

    // Direct convolution of the shared coefficient set with the channel history.
    function automatic int modelOut(input int c);
        longint acc = 0;
        for (int k = 0; k < NTAPS; k++)
            acc += longint'(h1[k]) * longint'(hist[c][(mp - k + NTAPS) % NTAPS]);
        acc = (acc + (longint'(1) << (CW - 2))) >>> (CW - 1);
        if (acc > YMAX) return YMAX;
        if (acc < YMIN) return YMIN;
        return int'(acc);
    endfunction

    task automatic waitIdle();
        int n = 0;
        while (busy && n < 2000) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (busy)
            checkOutput("idle_timeout", busy, 0);
    endtask

    // Drive one sample set, optionally a second endata (with clear_ovr) at cycle pulse_at,
    // then pop the scoreboard when dout_valid appears and check the latency.
    task automatic applyStimulus(input int x0, input int x1, input logic [1:0] byp,
                                 input bit use_model, input int t0, input int t1,
                                 input int pulse_at, input bit pulse_clr,
                                 output int got0, output int got1);
        exp_t e;
        exp_t p;
        int   cyc;
        bit   seen;
        waitIdle();
        modelPush(x0, x1);
        if (use_model) begin
            e.e0 = byp[0] ? x0 : modelOut(0);
            e.e1 = byp[1] ? x1 : modelOut(1);
        end else begin
            e.e0 = t0;
            e.e1 = t1;
        end
        sb.push_back(e);
        exp_pulses++;
        datain = {DW'(x1), DW'(x0)};
        bypass = byp;
        endata = 1'b1;
        cyc = 0;
        seen = 1'b0;
        got0 = 0;
        got1 = 0;
        while (!seen && cyc < LAT + 50) begin
            @(posedge clock);
            cyc++;
            #1;
            endata    = (cyc == pulse_at);
            clear_ovr = (cyc == pulse_at) && pulse_clr;
            if (dout_valid) begin
                seen = 1'b1;
                got0 = getCh(dataout, 0);
                got1 = getCh(dataout, 1);
                checkOutput("latency", cyc, LAT);
                if (sb.size() > 0) begin
                    p = sb.pop_front();
                    checkOutput("ch0_out", got0, p.e0);
                    checkOutput("ch1_out", got1, p.e1);
                end
            end
        end
        endata = 1'b0;
        clear_ovr = 1'b0;
        if (!seen) begin
            checkOutput("dout_valid_timeout", 0, 1);
            if (sb.size() > 0)
                void'(sb.pop_front());
        end
    endtask

    initial begin
        vec_t vecs [5];
        int g0, g1, cyc, nz, peak, max2;

        for (int k = 0; k < NTAPS; k++) h1[k] = 0;
        for (int k = 0; k < 2*NTAPS; k++) h2[k] = 0;
        modelReset();

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        checkOutput("rst_busy", busy, 1);
        checkOutput("rst_dout_valid", dout_valid, 0);
        checkOutput("rst_overrun", overrun, 0);
        checkOutput("rst_dataout", dataout, 0);
        checkOutput("rst_coefaddress", coefaddress, 0);

        // INIT length, with an endata landing in the middle of it
        @(negedge clock);
        reset_n = 1'b1;
        cyc = 0;
        while (busy && cyc < 1000) begin
            @(posedge clock);
            cyc++;
            #1;
            endata = (cyc == 10);
        end
        endata = 1'b0;
        checkOutput("init_cycles", cyc, NCH * NTAPS);
        checkOutput("init_overrun", overrun, 1);
        checkOutput("init_dataout", dataout, 0);
        checkOutput("init_pulses", pulses, 0);

        clear_ovr = 1'b1;
        @(posedge clock);
        #1;
        clear_ovr = 1'b0;
        checkOutput("clear_ovr", overrun, 0);

        // Unity-half gain on tap 0 with bypass combinations
        h1[0] = 16384;
        vecs[0] = '{1000, -2000, 2'b00, 500, -1000};
        vecs[1] = '{-1, 1, 2'b00, 0, 1};
        vecs[2] = '{131071, -131072, 2'b00, 65536, -65536};
        vecs[3] = '{1000, -2000, 2'b10, 500, -2000};
        vecs[4] = '{700, 333, 2'b01, 700, 167};
        for (int i = 0; i < 5; i++)
            applyStimulus(vecs[i].x0, vecs[i].x1, vecs[i].byp, 1'b0, vecs[i].e0, vecs[i].e1,
                          0, 1'b0, g0, g1);
        repeat (5) @(posedge clock);
        #1;
        checkOutput("hold_ch0", getCh(dataout, 0), 700);
        checkOutput("hold_ch1", getCh(dataout, 1), 167);

        // Second endata while busy is dropped and flagged
        applyStimulus(1000, -2000, 2'b00, 1'b0, 500, -1000, 50, 1'b0, g0, g1);
        checkOutput("ovr_set", overrun, 1);
        clear_ovr = 1'b1;
        @(posedge clock);
        #1;
        clear_ovr = 1'b0;
        checkOutput("ovr_clear", overrun, 0);
        applyStimulus(1000, -2000, 2'b00, 1'b0, 500, -1000, 50, 1'b1, g0, g1);
        checkOutput("ovr_set_wins", overrun, 1);
        repeat (2) @(posedge clock);
        #1;
        checkOutput("ovr_pulses", pulses, exp_pulses);
        clear_ovr = 1'b1;
        @(posedge clock);
        #1;
        clear_ovr = 1'b0;

        // Impulse through tap 3, twice so the second one lands after the write pointer wraps
        h1[0] = 0;
        h1[3] = 16384;
        for (int s = 0; s < 4; s++)
            applyStimulus(0, 0, 2'b00, 1'b1, 0, 0, 0, 1'b0, g0, g1);
        for (int blk = 0; blk < 2; blk++) begin
            nz = 0;
            peak = 0;
            for (int s = 0; s < 70; s++) begin
                applyStimulus((s == 0) ? 131071 : 0, 0, 2'b00, 1'b1, 0, 0, 0, 1'b0, g0, g1);
                if (g0 != 0 || g1 != 0) nz++;
                if (s == 3) peak = g0;
            end
            checkOutput("imp_peak", peak, 65536);
            checkOutput("imp_nonzero", nz, 1);
        end

        // Saturation at both rails with every tap at full scale
        for (int k = 0; k < NTAPS; k++) h1[k] = 32767;
        for (int s = 0; s < NTAPS; s++)
            applyStimulus(131071, 131071, 2'b00, 1'b1, 0, 0, 0, 1'b0, g0, g1);
        checkOutput("sat_hi_ch0", g0, 131071);
        checkOutput("sat_hi_ch1", g1, 131071);
        for (int s = 0; s < NTAPS; s++)
            applyStimulus(-131072, -131072, 2'b00, 1'b1, 0, 0, 0, 1'b0, g0, g1);
        checkOutput("sat_lo_ch0", g0, -131072);
        checkOutput("sat_lo_ch1", g1, -131072);

        // Reset during MAC: no output, INIT re-runs, history is cleared
        for (int k = 0; k < NTAPS; k++) h1[k] = 16384;
        waitIdle();
        datain = {DW'(20000), DW'(20000)};
        endata = 1'b1;
        repeat (40) begin
            @(posedge clock);
            #1;
            endata = 1'b0;
        end
        reset_n = 1'b0;
        #1;
        checkOutput("midrst_busy", busy, 1);
        checkOutput("midrst_dout_valid", dout_valid, 0);
        checkOutput("midrst_dataout", dataout, 0);
        modelReset();
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        cyc = 0;
        while (busy && cyc < 1000) begin
            @(posedge clock);
            cyc++;
            #1;
        end
        checkOutput("reinit_cycles", cyc, NCH * NTAPS);
        checkOutput("midrst_pulses", pulses, exp_pulses);
        applyStimulus(100, -100, 2'b00, 1'b0, 50, -50, 0, 1'b0, g0, g1);

        // Per-channel coefficient banks
        h2[0] = 16384;
        h2[NTAPS] = 8192;
        cyc = 0;
        while (busy2 && cyc < 2000) begin
            @(posedge clock);
            cyc++;
            #1;
        end
        checkOutput("banks_idle", busy2, 0);
        datain2 = {DW'(800), DW'(800)};
        endata2 = 1'b1;
        cyc = 0;
        max2 = 0;
        while (!dout_valid2 && cyc < LAT + 50) begin
            @(posedge clock);
            cyc++;
            #1;
            endata2 = 1'b0;
            if (int'(coefaddress2) > max2) max2 = int'(coefaddress2);
        end
        checkOutput("banks_latency", cyc, LAT);
        checkOutput("banks_ch0", getCh(dataout2, 0), 400);
        checkOutput("banks_ch1", getCh(dataout2, 1), 200);
        checkOutput("banks_max_addr", max2, 2 * NTAPS - 1);
        checkOutput("banks_overrun", overrun2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
